// File: rtl/rvtu_cluster_ctrl.sv
// rtl/rvtu_cluster_ctrl.sv - run controller for an N-core RVTU cluster
//
// Holds each core in reset until its autoconfig reports init_done. It then
// collects sticky halts, captures the first error and raises a single
// done/fail verdict, with an optional cycle watchdog.
//
// Optional feature: define RVTU_CLUSTER_STAGGER_EN to release cores strictly
// in index order, one per cycle. Left undefined, every core releases
// independently.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   init_done   per-core autoconfig complete (level or pulse)
//   halt        per-core halt (level or pulse)
//   err         per-core error
//   wdog_limit  watchdog limit in cycles, 0 disables it
//   core_rst    per-core reset to rvtu_pair (1 = held in reset)
//   halt_mask   sticky per-core halt seen
//   cycles      cycles spent in INIT+RUN, saturating
//   done, fail  final verdict, mutually exclusive
//   fail_code   0 none, 1 core error, 2 watchdog timeout
//   fail_core   lowest-index core that raised err (0 for a timeout)
module rvtu_cluster_ctrl #(
    parameter int N_CORES = 4,
    parameter int CYC_W   = 32,
    localparam int IDX_W  = $clog2(N_CORES > 1 ? N_CORES : 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CORES-1:0] init_done,
    input  logic [N_CORES-1:0] halt,
    input  logic [N_CORES-1:0] err,
    input  logic [CYC_W-1:0]   wdog_limit,
    output logic [N_CORES-1:0] core_rst,
    output logic [N_CORES-1:0] halt_mask,
    output logic [CYC_W-1:0]   cycles,
    output logic               done,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [IDX_W-1:0]   fail_core
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [N_CORES-1:0] init_seen, init_seen_nxt;
    logic [N_CORES-1:0] core_rst_nxt, halt_mask_nxt;
    logic [CYC_W-1:0]   cycles_nxt;
    logic               done_nxt, fail_nxt;
    logic [1:0]         fail_code_nxt;
    logic [IDX_W-1:0]   fail_core_nxt;

    logic [N_CORES-1:0] seen_now, release_ok, gated_err, gated_halt;
    logic [IDX_W-1:0]   err_idx;
    logic               wdog_hit;

    always_comb begin
        seen_now   = init_seen | init_done;
`ifdef RVTU_CLUSTER_STAGGER_EN
        // Bit i of ~(core_rst << 1) is "core i-1 is already out of reset";
        // bit 0 is always 1. Using the registered core_rst means a core can
        // follow its predecessor no earlier than the next cycle.
        release_ok = seen_now & ~(core_rst << 1);
`else
        release_ok = seen_now;
`endif
        // A core still in reset cannot halt or fail.
        gated_err  = err & ~core_rst;
        gated_halt = halt & ~core_rst;

        err_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (gated_err[i]) begin
                err_idx = IDX_W'(i);
            end
        end

        wdog_hit = (wdog_limit != '0) && (cycles >= wdog_limit);

        state_nxt     = state;
        init_seen_nxt = init_seen;
        core_rst_nxt  = core_rst;
        halt_mask_nxt = halt_mask;
        cycles_nxt    = cycles;
        done_nxt      = done;
        fail_nxt      = fail;
        fail_code_nxt = fail_code;
        fail_core_nxt = fail_core;

        if (state == ST_INIT || state == ST_RUN) begin
            init_seen_nxt = seen_now;
            core_rst_nxt  = core_rst & ~release_ok;
            halt_mask_nxt = halt_mask | gated_halt;

            // Verdict priority: error, then watchdog, then clean completion.
            // The counter does not advance on the edge that ends the run.
            if (gated_err != '0) begin
                state_nxt     = ST_FAIL;
                fail_nxt      = 1'b1;
                fail_code_nxt = 2'd1;
                fail_core_nxt = err_idx;
                core_rst_nxt  = '1;
            end else if (wdog_hit) begin
                state_nxt     = ST_FAIL;
                fail_nxt      = 1'b1;
                fail_code_nxt = 2'd2;
                fail_core_nxt = '0;
                core_rst_nxt  = '1;
            end else if (&halt_mask) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end else begin
                if (state == ST_INIT && (&init_seen)) begin
                    state_nxt = ST_RUN;
                end
                if (cycles != '1) begin
                    cycles_nxt = cycles + CYC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_seen <= '0;
            core_rst  <= '1;
            halt_mask <= '0;
            cycles    <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            fail_core <= '0;
        end else begin
            state     <= state_nxt;
            init_seen <= init_seen_nxt;
            core_rst  <= core_rst_nxt;
            halt_mask <= halt_mask_nxt;
            cycles    <= cycles_nxt;
            done      <= done_nxt;
            fail      <= fail_nxt;
            fail_code <= fail_code_nxt;
            fail_core <= fail_core_nxt;
        end
    end

endmodule

// File: tb/tb_rvtu_cluster_ctrl.sv
// tb/tb_rvtu_cluster_ctrl.sv - self-checking bench for rvtu_cluster_ctrl
module tb_rvtu_cluster_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] init_done, halt, err;
    logic [W-1:0] wdog_limit;
    logic [N-1:0] core_rst, halt_mask;
    logic [W-1:0] cycles;
    logic         done, fail;
    logic [1:0]   fail_code;
    logic [1:0]   fail_core;

    rvtu_cluster_ctrl #(.N_CORES(N), .CYC_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .halt       (halt),
        .err        (err),
        .wdog_limit (wdog_limit),
        .core_rst   (core_rst),
        .halt_mask  (halt_mask),
        .cycles     (cycles),
        .done       (done),
        .fail       (fail),
        .fail_code  (fail_code),
        .fail_core  (fail_core)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // event schedule: cycle at which each core's pulse is driven, -1 = never
    int init_at[N];
    int halt_at[N];
    int err_at[N];

    // behavioural model: per-core flags, verdict 0 running / 1 done / 2 fail
    bit     m_seen[N];
    bit     m_rel[N];
    bit     m_halted[N];
    int     m_over, m_code, m_core;
    longint m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_seen[i]   = 1'b0;
            m_rel[i]    = 1'b0;
            m_halted[i] = 1'b0;
        end
        m_over   = 0;
        m_code   = 0;
        m_core   = 0;
        m_cycles = 0;
    endtask

    task automatic model_step(input logic [N-1:0] id, input logic [N-1:0] h,
                              input logic [N-1:0] e, input longint lim);
        int ecore = -1;
        bit all_h = 1'b1;
        bit was_rel[N];
        if (m_over != 0) return;
        was_rel = m_rel;
        for (int i = 0; i < N; i++) begin
            if (e[i] && was_rel[i] && ecore < 0) ecore = i;
            if (!m_halted[i]) all_h = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            m_seen[i] = m_seen[i] | id[i];
            if (was_rel[i] && h[i]) m_halted[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
`ifdef RVTU_CLUSTER_STAGGER_EN
            if (m_seen[i] && (i == 0 || was_rel[(i > 0) ? i - 1 : 0])) m_rel[i] = 1'b1;
`else
            if (m_seen[i]) m_rel[i] = 1'b1;
`endif
        end
        if (ecore >= 0) begin
            m_over = 2; m_code = 1; m_core = ecore;
            for (int i = 0; i < N; i++) m_rel[i] = 1'b0;
        end else if (lim != 0 && m_cycles >= lim) begin
            m_over = 2; m_code = 2; m_core = 0;
            for (int i = 0; i < N; i++) m_rel[i] = 1'b0;
        end else if (all_h) begin
            m_over = 1;
        end else if (m_cycles < 64'hFFFF_FFFF) begin
            m_cycles++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] e_rst, e_hm;
        for (int i = 0; i < N; i++) begin
            e_rst[i] = !m_rel[i];
            e_hm[i]  = m_halted[i];
        end
        chk("core_rst",  64'(core_rst),  64'(e_rst));
        chk("halt_mask", 64'(halt_mask), 64'(e_hm));
        chk("cycles",    64'(cycles),    64'(m_cycles));
        chk("done",      64'(done),      64'(m_over == 1));
        chk("fail",      64'(fail),      64'(m_over == 2));
        chk("fail_code", 64'(fail_code), 64'(m_code));
        chk("fail_core", 64'(fail_core), 64'(m_core));
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) begin
            init_done[i] = (init_at[i] == cyc);
            halt[i]      = (halt_at[i] == cyc);
            err[i]       = (err_at[i] == cyc);
        end
        @(posedge clk);
        #1;
        model_step(init_done, halt, err, longint'(wdog_limit));
        cyc++;
        compare_all();
    endtask

    task automatic run_to(input int endc);
        while (cyc < endc) step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        init_done = '0;
        halt      = '0;
        err       = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc = 0;
        compare_all();
    endtask

    task automatic sched_basic();
        init_at = '{2, 5, 5, 9};
        halt_at = '{20, 22, 30, 31};
        err_at  = '{-1, -1, -1, -1};
    endtask

    initial begin
        rst        = 1'b1;
        wdog_limit = '0;
        cyc        = 0;

        // basic run to completion
        sched_basic();
        do_reset();
        run_to(3);  chk("t1_rel0", 64'(core_rst), 64'b1110);
        run_to(6);  chk("t1_rel12", 64'(core_rst), 64'b1000);
        run_to(10); chk("t1_rel3", 64'(core_rst), 64'b0000);
        run_to(32); chk("t1_done_early", 64'(done), 64'd0);
        run_to(33); chk("t1_done", 64'(done), 64'd1);
        run_to(40); chk("t1_cycles", 64'(cycles), 64'd32);
        chk("t1_fail", 64'(fail), 64'd0);

        // two simultaneous errors: lowest index wins
        sched_basic();
        halt_at = '{-1, -1, -1, -1};
        err_at  = '{-1, -1, 15, 15};
        do_reset();
        run_to(15); chk("t2_fail_early", 64'(fail), 64'd0);
        run_to(16); chk("t2_fail", 64'(fail), 64'd1);
        chk("t2_code", 64'(fail_code), 64'd1);
        chk("t2_core", 64'(fail_core), 64'd2);
        chk("t2_rst", 64'(core_rst), 64'b1111);
        run_to(20);

        // error while in reset is ignored; after release it is not
        sched_basic();
        halt_at = '{-1, -1, -1, -1};
        err_at  = '{-1, 3, -1, -1};
        do_reset();
        run_to(12); chk("t3_ignored", 64'(fail), 64'd0);
        err_at[1] = 12;
        run_to(13); chk("t3_code", 64'(fail_code), 64'd1);
        chk("t3_core", 64'(fail_core), 64'd1);
        run_to(16);

        // watchdog timeout, core 3 never halts
        sched_basic();
        halt_at[3] = -1;
        wdog_limit = 32'd100;
        do_reset();
        run_to(100); chk("t4_fail_early", 64'(fail), 64'd0);
        chk("t4_cyc100", 64'(cycles), 64'd100);
        run_to(101); chk("t4_fail", 64'(fail), 64'd1);
        chk("t4_code", 64'(fail_code), 64'd2);
        run_to(110); chk("t4_cycles", 64'(cycles), 64'd100);
        wdog_limit = '0;

        // final halt and error on the same edge: error wins
        sched_basic();
        err_at[0] = 31;
        do_reset();
        run_to(33); chk("t5_fail", 64'(fail), 64'd1);
        chk("t5_code", 64'(fail_code), 64'd1);
        chk("t5_core", 64'(fail_core), 64'd0);
        chk("t5_done", 64'(done), 64'd0);

        // reset mid-run, then the sequence repeats cleanly
        sched_basic();
        halt_at[0] = 12;
        do_reset();
        run_to(15); chk("t6_mask_pre", 64'(halt_mask), 64'b0001);
        do_reset();
        chk("t6_rst", 64'(core_rst), 64'b1111);
        chk("t6_mask", 64'(halt_mask), 64'd0);
        chk("t6_cycles", 64'(cycles), 64'd0);
        sched_basic();
        run_to(33); chk("t6_done", 64'(done), 64'd1);
        chk("t6_cycles_end", 64'(cycles), 64'd32);

`ifdef RVTU_CLUSTER_STAGGER_EN
        // ordered release, one core per cycle
        init_at = '{10, 10, 10, 1};
        halt_at = '{-1, -1, -1, -1};
        err_at  = '{-1, -1, -1, -1};
        do_reset();
        run_to(10); chk("st_held", 64'(core_rst), 64'b1111);
        run_to(11); chk("st_rel0", 64'(core_rst), 64'b1110);
        run_to(12); chk("st_rel1", 64'(core_rst), 64'b1100);
        run_to(13); chk("st_rel2", 64'(core_rst), 64'b1000);
        run_to(14); chk("st_rel3", 64'(core_rst), 64'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
